flag_capture_fifo: RTL and testbench

Downstream consumer of the 5-bit JK-flip-flop counter stage (`hello`: `q[4:0]`, `flag`).

- Detects each rising edge of the counter's `flag` output.
- Captures the counter value present on that cycle into a small show-ahead FIFO.
- Tags each accepted capture with a sequence number.
- Presents entries on a valid/ready port for a later consumer (display/logger).
- Keeps a saturating count of all flag events and a sticky overflow indicator.

---
 rtl/flag_capture_fifo_pkg.sv | 13 +
 rtl/flag_capture_fifo_if.sv | 25 ++
 rtl/capture_defs.vh | 7 +
 rtl/capture_fifo_mem.sv | 47 ++++
 rtl/flag_capture_fifo.sv | 75 +++++++
 tb/tb_flag_capture_fifo.sv | 219 +++++++++++++++++++++
 6 files changed

// File: rtl/flag_capture_fifo_pkg.sv
// rtl/flag_capture_fifo_pkg.sv - constants and helpers for flag_capture_fifo
package flag_capture_fifo_pkg;
`include "capture_defs.vh"

    localparam int SEQ_W     = `CAP_SEQ_W;
    localparam int CNT_W     = `CAP_CNT_W;
    localparam int DEPTH_DEF = `CAP_DEPTH_DEF;

    // Event counter that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/flag_capture_fifo_if.sv
// rtl/flag_capture_fifo_if.sv - valid/ready output port of the capture FIFO
interface flag_capture_fifo_if
    import flag_capture_fifo_pkg::*;
#(
    parameter int W = 5
);
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [SEQ_W-1:0] out_seq;

    modport master (
        output out_valid,
        output out_data,
        output out_seq,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_seq,
        output out_ready
    );
endinterface

// File: rtl/capture_defs.vh
// rtl/capture_defs.vh - shared width/depth constants for the flag capture block
`ifndef CAPTURE_DEFS_VH
`define CAPTURE_DEFS_VH
`define CAP_SEQ_W 3
`define CAP_CNT_W 8
`define CAP_DEPTH_DEF 4
`endif

// File: rtl/capture_fifo_mem.sv
// rtl/capture_fifo_mem.sv - show-ahead storage with pointers and explicit occupancy
module capture_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int DW    = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic [LW-1:0] level
);
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Head is read combinationally so an entry is visible right after its push edge
    assign rdata = mem[rd_ptr];

    // Storage, pointers and occupancy; push while full relies on the caller also popping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/flag_capture_fifo.sv
// rtl/flag_capture_fifo.sv - captures counter value on each flag rising edge into a FIFO
module flag_capture_fifo
    import flag_capture_fifo_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int W     = 5,
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [W-1:0]         q_in,
    input  logic                 flag_in,
    flag_capture_fifo_if.master  cap,
    output logic [LW-1:0]        level,
    output logic                 overflow,
    output logic [CNT_W-1:0]     flag_count
);
    logic             flag_d;
    logic             rise;
    logic             pop;
    logic             room;
    logic             push;
    logic [SEQ_W-1:0] seq;
    logic [W+SEQ_W-1:0] head;

    assign rise          = flag_in & ~flag_d;
    assign cap.out_valid = (level != '0);
    assign pop           = cap.out_valid & cap.out_ready;
    // A full FIFO still has room when the head leaves on the same edge
    assign room          = (level < LW'(DEPTH)) | pop;
    assign push          = rise & room;
    assign cap.out_data  = head[W+SEQ_W-1:SEQ_W];
    assign cap.out_seq   = head[SEQ_W-1:0];

    // Edge detector resets high so a flag held through reset release is ignored
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flag_d <= 1'b1;
        end else begin
            flag_d <= flag_in;
        end
    end

    // Sequence tag advances only for accepted captures; drops make overflow sticky
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seq        <= '0;
            overflow   <= 1'b0;
            flag_count <= '0;
        end else begin
            if (push) begin
                seq <= seq + 1'b1;
            end
            if (rise && !room) begin
                overflow <= 1'b1;
            end
            if (rise) begin
                flag_count <= sat_inc(flag_count);
            end
        end
    end

    capture_fifo_mem #(
        .DEPTH (DEPTH),
        .DW    (W + SEQ_W)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata ({q_in, seq}),
        .rdata (head),
        .level (level)
    );
endmodule

// File: tb/tb_flag_capture_fifo.sv
// tb/tb_flag_capture_fifo.sv - directed self-checking bench for flag_capture_fifo
module tb_flag_capture_fifo;
    import flag_capture_fifo_pkg::*;

    logic       clk;
    logic       reset;
    logic [4:0] q_in;
    logic       flag_in;
    logic [2:0] level;
    logic       overflow;
    logic [7:0] flag_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    int         k;
    logic       prev_f;

    flag_capture_fifo_if #(.W(5)) bus ();

    flag_capture_fifo #(.DEPTH(DEPTH_DEF), .W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .q_in       (q_in),
        .flag_in    (flag_in),
        .cap        (bus),
        .level      (level),
        .overflow   (overflow),
        .flag_count (flag_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        flag_in    = 1'b0;
        bus.out_ready = 1'b0;
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic pulse(input logic [4:0] v);
        q_in    = v;
        flag_in = 1'b1;
        step();
        flag_in = 1'b0;
        step();
    endtask

    task automatic stream_cycle(input logic f, input logic r);
        logic       v;
        logic [4:0] d;
        logic [2:0] s;
        flag_in       = f;
        q_in          = 5'(k * 7 + 3);
        bus.out_ready = r;
        v = bus.out_valid;
        d = bus.out_data;
        s = bus.out_seq;
        if (v && r) begin
            check("strm_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("strm_data", 32'(d), 32'(exp_q[0][7:3]));
                check("strm_seq", 32'(s), 32'(exp_q[0][2:0]));
                void'(exp_q.pop_front());
            end
        end
        if (f && !prev_f) begin
            exp_q.push_back({q_in, 3'(k)});
            k++;
        end
        prev_f = f;
        step();
        if (v && !r) begin
            check("stall_data", 32'(bus.out_data), 32'(d));
            check("stall_seq", 32'(bus.out_seq), 32'(s));
        end
        check("strm_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
    endtask

    initial begin
        // reset with flag held high
        reset         = 1'b0;
        flag_in       = 1'b1;
        q_in          = 5'd9;
        bus.out_ready = 1'b0;
        step();
        step();
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data", 32'(bus.out_data), 32'd0);
        check("rst_seq", 32'(bus.out_seq), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_cnt", 32'(flag_count), 32'd0);
        reset = 1'b1;
        step();
        step();
        check("rel_level", 32'(level), 32'd0);
        check("rel_cnt", 32'(flag_count), 32'd0);
        flag_in = 1'b0;
        step();
        check("rel_low_level", 32'(level), 32'd0);

        // single capture
        q_in    = 5'd17;
        flag_in = 1'b1;
        step();
        check("one_valid", 32'(bus.out_valid), 32'd1);
        check("one_data", 32'(bus.out_data), 32'd17);
        check("one_seq", 32'(bus.out_seq), 32'd0);
        check("one_level", 32'(level), 32'd1);
        check("one_cnt", 32'(flag_count), 32'd1);
        flag_in = 1'b0;
        step();
        check("one_held_level", 32'(level), 32'd1);

        // overflow with six pulses into a four-entry FIFO
        do_reset();
        for (int i = 1; i <= 6; i++) pulse(5'(i));
        check("ovf_level", 32'(level), 32'd4);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_cnt", 32'(flag_count), 32'd6);
        check("ovf_head_data", 32'(bus.out_data), 32'd1);
        check("ovf_head_seq", 32'(bus.out_seq), 32'd0);

        // push and pop on the same edge while full
        q_in          = 5'd20;
        flag_in       = 1'b1;
        bus.out_ready = 1'b1;
        step();
        flag_in       = 1'b0;
        bus.out_ready = 1'b0;
        check("pp_level", 32'(level), 32'd4);
        check("pp_head_data", 32'(bus.out_data), 32'd2);
        check("pp_head_seq", 32'(bus.out_seq), 32'd1);
        check("pp_ovf", 32'(overflow), 32'd1);
        check("pp_cnt", 32'(flag_count), 32'd7);
        begin
            logic [4:0] ed [4];
            logic [2:0] es [4];
            ed = '{5'd2, 5'd3, 5'd4, 5'd20};
            es = '{3'd1, 3'd2, 3'd3, 3'd4};
            for (int i = 0; i < 4; i++) begin
                check("drain_valid", 32'(bus.out_valid), 32'd1);
                check("drain_data", 32'(bus.out_data), 32'(ed[i]));
                check("drain_seq", 32'(bus.out_seq), 32'(es[i]));
                bus.out_ready = 1'b1;
                step();
                bus.out_ready = 1'b0;
            end
        end
        check("drain_empty", 32'(bus.out_valid), 32'd0);
        check("drain_level", 32'(level), 32'd0);

        // long stream with wrap and stalls
        do_reset();
        k      = 0;
        prev_f = 1'b0;
        exp_q.delete();
        for (int c = 0; c < 40; c++) stream_cycle(c[0], ~c[0]);
        for (int c = 0; c < 8; c++) stream_cycle(1'b0, 1'b1);
        check("strm_captures", 32'(k), 32'd20);
        check("strm_left", 32'(exp_q.size()), 32'd0);
        check("strm_ovf", 32'(overflow), 32'd0);
        check("strm_cnt", 32'(flag_count), 32'd20);

        // saturation of the flag counter
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 300; i++) pulse(5'(i));
        check("sat_cnt", 32'(flag_count), 32'd255);
        check("sat_ovf", 32'(overflow), 32'd0);
        bus.out_ready = 1'b0;
        q_in    = 5'd3;
        flag_in = 1'b1;
        step();
        check("sat_hold", 32'(flag_count), 32'd255);
        check("pre_rst_valid", 32'(bus.out_valid), 32'd1);

        // asynchronous reset mid-stream
        reset = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_cnt", 32'(flag_count), 32'd0);
        check("mid_rst_data", 32'(bus.out_data), 32'd0);
        flag_in = 1'b0;
        step();
        reset = 1'b1;
        step();
        q_in    = 5'd7;
        flag_in = 1'b1;
        step();
        flag_in = 1'b0;
        check("post_valid", 32'(bus.out_valid), 32'd1);
        check("post_data", 32'(bus.out_data), 32'd7);
        check("post_seq", 32'(bus.out_seq), 32'd0);
        check("post_cnt", 32'(flag_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
